// File: rtl/qb_sweep_pkg.sv
// Shared types and sizes for the qb truth-table sweeper.
package qb_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t;

  localparam int VEC_W = 5;
  localparam int N_VEC = 32;

endpackage

// File: rtl/qb_sweep_qb.sv
// qb: 5-input combinational function under test, Y over {A,B,C,D,E} (A is the MSB).
module qb (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  output logic Y
);

  // Sum-of-products form of the reference table 0xFFBF111F
  assign Y = (A & (B | ~C | ~D | E)) | (~A & ~D & ~E) | (~A & ~B & ~C);

endmodule

// File: rtl/qb_sweep.sv
// Walks all 32 input vectors through a qb instance, builds the truth table
// and compares it against a caller-supplied reference table.
module qb_sweep
  import qb_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] expected,
  output logic        busy,
  output logic        done,
  output logic [31:0] tt,
  output logic [5:0]  ones,
  output logic        match,
  output logic [4:0]  mismatch_idx
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(N_VEC - 1);

  sweep_state_t     state;
  logic [VEC_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [N_VEC-1:0] exp_q;
  logic             mm_seen;
  logic             y;
  logic             y_bad;

  // idx is a register, so qb sees a clean vector for the whole settle window
  qb u_qb (
    .A(idx[4]),
    .B(idx[3]),
    .C(idx[2]),
    .D(idx[1]),
    .E(idx[0]),
    .Y(y)
  );

  assign y_bad = (y != exp_q[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      exp_q        <= '0;
      mm_seen      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt           <= '0;
      ones         <= '0;
      match        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= DRIVE;
            busy         <= 1'b1;
            idx          <= '0;
            cnt          <= '0;
            tt           <= '0;
            ones         <= '0;
            match        <= 1'b0;
            mismatch_idx <= '0;
            exp_q        <= expected;
            mm_seen      <= 1'b0;
          end
        end
        DRIVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          tt[idx] <= y;
          ones    <= ones + {5'b0, y};
          if (y_bad && !mm_seen) begin
            mismatch_idx <= idx;
            mm_seen      <= 1'b1;
          end
          if (idx == IDX_LAST) begin
            // match is presented together with done, so fold in the last vector here
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= !(mm_seen || y_bad);
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= '0;
            state <= DRIVE;
          end
        end
        DONE: begin
          match <= !mm_seen;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qb_sweep.sv
// Scoreboard bench for qb_sweep with SETTLE=1 and SETTLE=3 instances.
module tb_qb_sweep;

  localparam logic [31:0] GOLDEN = 32'hFFBF111F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [31:0] exp1 = '0;
  logic [31:0] exp3 = '0;

  logic        busy1, done1, match1, busy3, done3, match3;
  logic [31:0] tt1, tt3;
  logic [5:0]  ones1, ones3;
  logic [4:0]  mmi1, mmi3;

  int total = 0;
  int bad   = 0;
  int sel   = 1;

  typedef struct packed {
    logic [31:0] tt;
    logic [5:0]  ones;
    logic        match;
    logic [4:0]  mmi;
  } res_t;

  res_t sb[$];

  logic       busy_m, done_m;
  res_t       out_m;
  logic [4:0] vec_m;

  always #5 clk = ~clk;

  qb_sweep #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1),
    .busy(busy1), .done(done1), .tt(tt1), .ones(ones1),
    .match(match1), .mismatch_idx(mmi1)
  );

  qb_sweep #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
    .busy(busy3), .done(done3), .tt(tt3), .ones(ones3),
    .match(match3), .mismatch_idx(mmi3)
  );

  assign busy_m = (sel == 3) ? busy3 : busy1;
  assign done_m = (sel == 3) ? done3 : done1;
  assign out_m  = (sel == 3) ? {tt3, ones3, match3, mmi3} : {tt1, ones1, match1, mmi1};
  assign vec_m  = (sel == 3) ? {dut3.u_qb.A, dut3.u_qb.B, dut3.u_qb.C, dut3.u_qb.D, dut3.u_qb.E}
                             : {dut1.u_qb.A, dut1.u_qb.B, dut1.u_qb.C, dut1.u_qb.D, dut1.u_qb.E};

  function automatic res_t model(input logic [31:0] e);
    res_t r;
    logic [31:0] g;
    g = GOLDEN;
    r.tt = g;
    r.ones = '0;
    r.match = 1'b1;
    r.mmi = '0;
    for (int i = 0; i < 32; i++) r.ones = r.ones + 6'(g[i]);
    for (int i = 31; i >= 0; i--) begin
      if (g[i] != e[i]) begin
        r.match = 1'b0;
        r.mmi = i[4:0];
      end
    end
    return r;
  endfunction

  task automatic do_sweep(input int which, input logic [31:0] e, input int settle,
                          input int rst_at, input bit chk_hold, input res_t held);
    res_t exp_r;
    int   last;
    int   vec_err;
    int   busy_err;
    bit   seen;
    sel = which;
    last = 1 + 32 * (settle + 1);
    vec_err = 0;
    busy_err = 0;
    seen = 1'b0;
    @(negedge clk);
    if (chk_hold) begin
      total++;
      if (out_m !== held) begin
        bad++;
        $display("FAIL hold_before_start: got %h want %h", out_m, held);
      end
    end
    if (which == 3) begin start3 = 1'b1; exp3 = e; end
    else begin start1 = 1'b1; exp1 = e; end
    sb.push_back(model(e));
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    for (int c = 1; c <= last + 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (out_m !== '0) begin
          bad++;
          $display("FAIL cleared_on_start: got %h want 0", out_m);
        end
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_m, done_m, out_m, vec_m} !== '0) begin
          bad++;
          $display("FAIL reset_mid_outputs: got %h want 0", {busy_m, done_m, out_m, vec_m});
        end
        repeat (2) begin
          @(negedge clk);
          if (done_m) seen = 1'b1;
        end
        total++;
        if (seen) begin
          bad++;
          $display("FAIL reset_no_done: got done=1 want done=0");
        end
        rst_n = 1'b1;
        void'(sb.pop_front());
        return;
      end
      if (which == 3) begin
        start3 = (c == 10 || c == 50);
        if (c == 20) exp3 = ~e;
      end
      if (done_m) begin
        seen = 1'b1;
        exp_r = sb.pop_front();
        total++;
        if (c != last) begin
          bad++;
          $display("FAIL done_cycle: got %0d want %0d", c, last);
        end
        total++;
        if (busy_m !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %b want 0", busy_m);
        end
        total++;
        if (out_m.tt !== exp_r.tt) begin
          bad++;
          $display("FAIL tt: got %h want %h", out_m.tt, exp_r.tt);
        end
        total++;
        if (out_m.ones !== exp_r.ones) begin
          bad++;
          $display("FAIL ones: got %0d want %0d", out_m.ones, exp_r.ones);
        end
        total++;
        if (out_m.match !== exp_r.match) begin
          bad++;
          $display("FAIL match: got %b want %b", out_m.match, exp_r.match);
        end
        total++;
        if (out_m.mmi !== exp_r.mmi) begin
          bad++;
          $display("FAIL mismatch_idx: got %0d want %0d", out_m.mmi, exp_r.mmi);
        end
      end else begin
        if (busy_m !== 1'b1) busy_err++;
        if (vec_m !== 5'((c - 1) / (settle + 1))) vec_err++;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done at cycle %0d", last);
      void'(sb.pop_front());
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL busy_during_sweep: got %0d low cycles want 0", busy_err);
    end
    total++;
    if (vec_err != 0) begin
      bad++;
      $display("FAIL vector_sequence: got %0d wrong cycles want 0", vec_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy1, done1, tt1, ones1, match1, mmi1, busy3, done3, tt3, ones3, match3, mmi3} !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got %h/%h want 0", i,
                 {busy1, done1, tt1, ones1, match1, mmi1}, {busy3, done3, tt3, ones3, match3, mmi3});
      end
    end
  endtask

  task automatic test_golden;
    do_sweep(1, GOLDEN, 1, 0, 1'b0, '0);
  endtask

  task automatic test_mismatch;
    do_sweep(1, 32'hFFBF111E, 1, 0, 1'b0, '0);
    do_sweep(1, 32'h7FBF011F, 1, 0, 1'b0, '0);
  endtask

  task automatic test_settle;
    do_sweep(3, GOLDEN, 3, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid;
    do_sweep(1, GOLDEN, 1, 30, 1'b0, '0);
    do_sweep(1, GOLDEN, 1, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back;
    do_sweep(1, GOLDEN, 1, 0, 1'b0, '0);
    do_sweep(1, 32'h0, 1, 0, 1'b1, model(GOLDEN));
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_settle();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/qb_sweep.md
# qb_sweep

Sequential truth-table sweeper wrapped around the 5-input combinational `qb` block. On `start` it drives all 32 input vectors into an internal `qb` instance and holds each vector for a programmable settle time. It samples `Y` for every vector, assembles the 32-bit truth table, counts the ones and compares the result against a caller-supplied expected table. It sits directly upstream of `qb`, generating its inputs, and consumes its output. It serves as the self-check stage in the lab top level.

## Interface
- `SETTLE`, default 1 (min 1): cycles each vector is held before sampling.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled only in IDLE.
- `expected` in 32: reference truth table, bit i = required Y for vector i; captured on start acceptance.
- `busy` out 1: high during DRIVE/SAMPLE.
- `done` out 1: one-cycle pulse when results are final.
- `tt` out 32: captured truth table, bit i = Y for vector i.
- `ones` out 6: number of ones in `tt`, 0..32.
- `match` out 1: `tt == expected`; valid from `done`.
- `mismatch_idx` out 5: lowest index i where `tt[i] != expected[i]`; 0 when `match`.

## Operation
- Vector mapping: `idx[4:0]` is driven as A=`idx[4]`, B=`idx[3]`, C=`idx[2]`, D=`idx[1]`, E=`idx[0]`. The vector is registered, so the `qb` inputs are glitch-free.
- States:
  - IDLE: on `start`, go to DRIVE. In the same edge: idx←0, cnt←0, `tt`←0, `ones`←0, `match`←0, `mismatch_idx`←0, `expected` captured into `exp_q`, internal `mm_seen`←0.
  - DRIVE: cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE.
  - SAMPLE: `tt[idx]`←Y and `ones`←`ones`+Y. If Y≠`exp_q[idx]` and !`mm_seen`, then `mismatch_idx`←idx and `mm_seen`←1. If idx==31, go to DONE; otherwise idx←idx+1, cnt←0, go to DRIVE.
  - DONE: `done`=1 for this cycle, `match`←!`mm_seen`, then go to IDLE.
- Results (`tt`, `ones`, `match`, `mismatch_idx`) hold their values after DONE until the next accepted start.
- `start` while busy or in DONE is ignored. `expected` changes after capture have no effect.
- `ones` width is 6 bits, so the all-ones table (32) does not overflow. idx never wraps; the sweep terminates at 31.
- Reset (any time, including mid-sweep): state→IDLE. All outputs are 0, including the driven vector (A..E=0), idx, cnt and `mm_seen`.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE. `busy` is high from cycle 1.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, then 1 in SAMPLE.
- `done` is high in cycle 1+32·(SETTLE+1): cycle 65 for SETTLE=1, cycle 129 for SETTLE=3. `busy` is low in that cycle.
- `tt`, `ones` and `mismatch_idx` update in SAMPLE cycles. `match` updates at the DONE edge.
- Earliest next start is the cycle after `done`, when the block is back in IDLE.

## Structure
- Package `qb_sweep_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t`
  - localparams `VEC_W=5`, `N_VEC=32`, `CNT_W=$clog2(SETTLE+1)`; `CNT_W` is computed in the module from `SETTLE`.
- One sub-module instance: `u_qb` of `qb`, with A..E driven from the registered vector and Y feeding the SAMPLE logic.
- The FSM, counters and result registers live in `qb_sweep` itself. No further hierarchy.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, no start. Required: all outputs 0 and `busy`=0 for 10 cycles.
- Golden sweep: SETTLE=1, `expected`=0xFFBF111F, pulse `start`. Required: `done` exactly at cycle 65, `tt`=0xFFBF111F, `ones`=22, `match`=1, `mismatch_idx`=0, `busy` high in cycles 1–64.
- Mismatch indices:
  - `expected`=0xFFBF111E gives `match`=0, `mismatch_idx`=0.
  - `expected`=0x7FBF011F gives `mismatch_idx`=12, the lowest of 12 and 31.
  - In both cases `tt` is still 0xFFBF111F.
- Settle length: SETTLE=3, golden `expected`. Required: `done` at cycle 129 and each A..E vector stable for 4 cycles. Also check that `start` pulses at cycles 10 and 50, and an `expected` change at cycle 20, have no effect.
- Reset mid-sweep: assert `rst_n`=0 at cycle 30 of a sweep. Required: outputs 0 immediately, with no `done`. A fresh start then gives the golden results at cycle 65.
- Back-to-back: start again in the cycle after `done` with `expected`=0. Required: previous results are held until acceptance, then cleared. Second sweep ends with `match`=0, `mismatch_idx`=0, `ones`=22.
